// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the f4/f5/f6 truth-table sweep sequencer.
// Golden columns are indexed by vector number {w,x,y,z}.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int NUM_VEC = 16;
  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  localparam logic [15:0] EXP_F4_DEF = 16'h8888;
  localparam logic [15:0] EXP_F5_DEF = 16'h111F;
  localparam logic [15:0] EXP_F6_DEF = 16'h212E;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/truth_sweep_ctrl_settle_timer.sv
// 4-bit down-counter: load takes priority over decrement, holds at zero.
// zero is a pure decode of the count register.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/truth_sweep_ctrl.sv
// Sweeps all 16 {w,x,y,z} vectors, holds each SETTLE_CYC+1 cycles, samples f4/f5/f6.
// Records truth table, compares against golden columns; done 16*(SETTLE_CYC+1)+1 cycles after start.
module truth_sweep_ctrl
  import truth_sweep_pkg::*;
#(
  parameter int          SETTLE_CYC = 2,
  parameter logic [15:0] EXP_F4     = EXP_F4_DEF,
  parameter logic [15:0] EXP_F5     = EXP_F5_DEF,
  parameter logic [15:0] EXP_F6     = EXP_F6_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f4,
  input  logic        f5,
  input  logic        f6,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        fail_valid,
  output logic [3:0]  first_fail_idx,
  output logic [15:0] tt_f4,
  output logic [15:0] tt_f5,
  output logic [15:0] tt_f6
);

  // Out-of-range settle times are clamped rather than wrapping the 4-bit counter.
  localparam int SETTLE_EFF = (SETTLE_CYC < SETTLE_MIN) ? SETTLE_MIN :
                              (SETTLE_CYC > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYC;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_EFF - 1);

  state_t     state_q, state_d;
  logic [3:0] idx;
  logic       timer_load, timer_dec, timer_zero;
  logic       sweep_start, sample_en, abort_go;
  logic       mis;
  logic [4:0] err_nxt;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    sweep_start = 1'b0;
    sample_en   = 1'b0;
    abort_go    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sweep_start = 1'b1;
          timer_load  = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) state_d   = ST_SAMPLE;
        else            timer_dec = 1'b1;
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if (idx == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including the sample of the current cycle.
    if (abort && (state_q != ST_IDLE)) begin
      abort_go   = 1'b1;
      sample_en  = 1'b0;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      state_d    = ST_IDLE;
    end
  end

  assign mis     = (f4 != EXP_F4[idx]) || (f5 != EXP_F5[idx]) || (f6 != EXP_F6[idx]);
  assign err_nxt = err_count + {4'd0, mis};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
      tt_f4          <= '0;
      tt_f5          <= '0;
      tt_f6          <= '0;
      pass           <= 1'b0;
    end else begin
      if (sweep_start) begin
        idx            <= '0;
        err_count      <= '0;
        fail_valid     <= 1'b0;
        first_fail_idx <= '0;
        tt_f4          <= '0;
        tt_f5          <= '0;
        tt_f6          <= '0;
        pass           <= 1'b0;
      end
      if (sample_en) begin
        tt_f4[idx] <= f4;
        tt_f5[idx] <= f5;
        tt_f6[idx] <= f6;
        if (mis) begin
          err_count <= err_nxt;
          if (!fail_valid) begin
            first_fail_idx <= idx;
            fail_valid     <= 1'b1;
          end
        end
        // pass becomes visible in the DONE cycle, built from the final count.
        if (idx == LAST_IDX) pass <= (err_nxt == 5'd0);
        else                 idx  <= idx + 4'd1;
      end
      if (abort_go || (state_q == ST_DONE)) idx <= '0;
      if (abort_go) pass <= 1'b0;
    end
  end

  assign {w, x, y, z} = idx;
  assign busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done = (state_q == ST_DONE) && !abort;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed bench for truth_sweep_ctrl: table of breadboard fault scenarios plus
// hand sequences for start re-pulse, abort, async reset and SETTLE_CYC = 1.
module tb_truth_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, start1, abort1;
  logic [1:0] fault;

  logic [15:0] g4 = 16'h8888;
  logic [15:0] g5 = 16'h111F;
  logic [15:0] g6 = 16'h212E;

  logic f4, f5, f6, w, x, y, z, busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [3:0] ffi, vec;
  logic [15:0] tt4, tt5, tt6;

  logic f4_1, f5_1, f6_1, w1, x1, y1, z1, busy1, done1, pass1, fv1;
  logic [4:0] err1;
  logic [3:0] ffi1, vec1;
  logic [15:0] tt4_1, tt5_1, tt6_1;

  // Breadboard model: golden function plus selectable faults.
  assign vec = {w, x, y, z};
  assign f4  = g4[vec] ^ (fault == 2'd3);
  assign f5  = (fault == 2'd2) ? 1'b1 : g5[vec];
  assign f6  = (fault == 2'd1) ? 1'b0 : g6[vec];

  assign vec1 = {w1, x1, y1, z1};
  assign f4_1 = g4[vec1];
  assign f5_1 = g5[vec1];
  assign f6_1 = g6[vec1];

  truth_sweep_ctrl #(.SETTLE_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f4(f4), .f5(f5), .f6(f6),
    .w(w), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_idx(ffi),
    .tt_f4(tt4), .tt_f5(tt5), .tt_f6(tt6)
  );

  truth_sweep_ctrl #(.SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .f4(f4_1), .f5(f5_1), .f6(f6_1),
    .w(w1), .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_idx(ffi1),
    .tt_f4(tt4_1), .tt_f5(tt5_1), .tt_f6(tt6_1)
  );

  typedef struct {
    logic [1:0]  fault;
    int          exp_cyc;
    logic        exp_pass;
    logic [4:0]  exp_err;
    logic        exp_fv;
    logic [3:0]  exp_ffi;
    logic [15:0] e4, e5, e6;
  } vec_t;

  vec_t tbl[4];
  int checks = 0;
  int failures = 0;
  int cyc, ndone, dcyc, bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
  endtask

  task automatic run_and_check(input vec_t v, input int n);
    fault = v.fault;
    pulse_start();
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check($sformatf("row%0d done_cycle", n), cyc, v.exp_cyc);
    check($sformatf("row%0d pass_in_done", n), pass, v.exp_pass);
    check($sformatf("row%0d busy_in_done", n), busy, 0);
    @(negedge clk);
    check($sformatf("row%0d done_pulse", n), done, 0);
    check($sformatf("row%0d err_count", n), err_count, v.exp_err);
    check($sformatf("row%0d fail_valid", n), fail_valid, v.exp_fv);
    check($sformatf("row%0d first_fail_idx", n), ffi, v.exp_ffi);
    check($sformatf("row%0d tt_f4", n), tt4, v.e4);
    check($sformatf("row%0d tt_f5", n), tt5, v.e5);
    check($sformatf("row%0d tt_f6", n), tt6, v.e6);
    check($sformatf("row%0d pass_after", n), pass, v.exp_pass);
    check($sformatf("row%0d vec_idle", n), vec, 0);
  endtask

  initial begin
    tbl[0] = '{2'd0, 49, 1'b1, 5'd0,  1'b0, 4'd0, 16'h8888, 16'h111F, 16'h212E};
    tbl[1] = '{2'd1, 49, 1'b0, 5'd6,  1'b1, 4'd1, 16'h8888, 16'h111F, 16'h0000};
    tbl[2] = '{2'd2, 49, 1'b0, 5'd9,  1'b1, 4'd5, 16'h8888, 16'hFFFF, 16'h212E};
    tbl[3] = '{2'd3, 49, 1'b0, 5'd16, 1'b1, 4'd0, 16'h7777, 16'h111F, 16'h212E};

    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0; fault = 2'd0;
    repeat (3) @(negedge clk);
    check("reset vec", vec, 0);
    check("reset status", {busy, done, pass, fail_valid}, 0);
    check("reset err_count", err_count, 0);
    check("reset first_fail_idx", ffi, 0);
    check("reset tt", {tt4, tt5}, 0);
    check("reset tt_f6", tt6, 0);
    check("reset vec1", vec1, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_and_check(tbl[i], i);

    // start re-pulsed mid-sweep and in the DONE cycle must be ignored
    fault = 2'd0;
    pulse_start();
    ndone = 0; dcyc = 0;
    for (int k = 0; k < 120; k++) begin
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = cyc;
        start = 1'b1;
      end else begin
        start = (cyc == 10);
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    check("repulse done_count", ndone, 1);
    check("repulse done_cycle", dcyc, 49);
    check("repulse busy_end", busy, 0);
    check("repulse pass", pass, 1);
    check("repulse tt_f6", tt6, 16'h212E);

    // abort in the SAMPLE cycle of vector 5 (cycle 18)
    pulse_start();
    while (cyc < 18) begin
      @(negedge clk); cyc++;
    end
    check("abort vec_at_sample", vec, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort vec", vec, 0);
    check("abort pass", pass, 0);
    check("abort tt_f4", tt4, 16'h0008);
    check("abort tt_f5", tt5, 16'h001F);
    check("abort tt_f6", tt6, 16'h000E);
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no_done", ndone, 0);

    // asynchronous reset while vector 9 is on the pins
    pulse_start();
    while (cyc < 29) begin
      @(negedge clk); cyc++;
    end
    check("rst vec_before", vec, 9);
    #2 rst = 1'b1;
    #1;
    check("rst async vec", vec, 0);
    check("rst async status", {busy, done, pass, fail_valid}, 0);
    check("rst async err", {err_count, ffi}, 0);
    check("rst async tt", {tt4, tt5}, 0);
    check("rst async tt_f6", tt6, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_and_check(tbl[0], 4);

    // SETTLE_CYC = 1 instance: two cycles per vector
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    cyc = 1; bad = 0;
    while (!done1 && cyc < 200) begin
      if (vec1 != 4'((cyc - 1) / 2)) bad++;
      @(negedge clk); cyc++;
    end
    check("s1 done_cycle", cyc, 33);
    check("s1 vec_steps", bad, 0);
    check("s1 pass", pass1, 1);
    check("s1 tt", {tt4_1, tt5_1}, {16'h8888, 16'h111F});
    check("s1 tt_f6", tt6_1, 16'h212E);
    check("s1 err", {busy1, fv1, err1, ffi1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
